log_ram_ctrl: RTL

//  Controller for the single-port violation-log RAM behind the logger. Shares the one
//  RAM port between logger writes, host readout and a clear sequencer. Logger writes
//  are buffered in a small FIFO so they are never stalled. Sits between logger/ram

---
 rtl/log_ram_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/log_ram_ctrl.sv
// rtl/log_ram_ctrl.sv - violation-log RAM port arbiter with logger write FIFO and clear sweep; optional LOG_CTRL_CNT_EN adds committed-write counter
module log_ram_ctrl #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 37,
  parameter int unsigned RAM_DEPTH  = 16'h0400,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              log_we,
  input  logic [ADDR_W-1:0] log_addr,
  input  logic [DATA_W-1:0] log_data,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              host_re,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ovf,
  output logic [ADDR_W-1:0] log_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [PTR_W:0]    FULL_FILL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] ptr_q;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q;
  logic [PTR_W:0]    rd_ptr_q;
  logic [PTR_W:0]    fill;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  head;

  logic              clr_accept;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ovf_q;

  // The extra pointer bit distinguishes full from empty.
  assign fill       = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == FULL_FILL);
  assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  // The FIFO drains whenever the sweep is not holding the port.
  assign pop        = (state_q == IDLE) && !fifo_empty;
  // A pop frees a slot in the same cycle, so a push at full still lands.
  assign push       = log_we && (!fifo_full || pop);
  assign clr_accept = (state_q == IDLE) && clr_req;
  assign clr_busy   = (state_q == CLEAR);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: one sweep of RAM_DEPTH writes, clr_req ignored while sweeping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_req) state_d = CLEAR;
      CLEAR:   if (ptr_q == LAST_ADDR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sweep address pointer, restarted on every accepted clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                ptr_q <= '0;
    else if (clr_accept)         ptr_q <= '0;
    else if (state_q == CLEAR)   ptr_q <= ptr_q + 1'b1;
  end

  // FIFO storage; contents are meaningless once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {log_addr, log_data};
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // RAM port mux: sweep write, then buffered log write, then host read.
  always_comb begin
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    host_ready = 1'b0;
    if (state_q == CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = ptr_q;
    end else if (!fifo_empty) begin
      ram_we    = 1'b1;
      ram_addr  = head[ENT_W-1:DATA_W];
      ram_wdata = head[DATA_W-1:0];
    end else if (host_re) begin
      host_ready = 1'b1;
      ram_re     = 1'b1;
      ram_addr   = host_addr;
    end
  end

  // Host read return: valid one cycle after grant, last word held afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= host_ready;
      if (rvalid_q) rdata_q <= ram_rdata;
    end
  end

  assign host_rvalid = rvalid_q;
  assign host_rdata  = rvalid_q ? ram_rdata : rdata_q;

  // Sticky overflow; a drop in the same cycle as a clear still reports.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      if (clr_accept)                    ovf_q <= 1'b0;
      if (log_we && fifo_full && !pop)   ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;

`ifdef LOG_CTRL_CNT_EN
  localparam logic [ADDR_W-1:0] CNT_MAX = ADDR_W'(RAM_DEPTH);
  logic [ADDR_W-1:0] cnt_q;

  // Committed log writes, saturating at the RAM depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       cnt_q <= '0;
    else if (clr_accept)                cnt_q <= '0;
    else if (pop && cnt_q != CNT_MAX)   cnt_q <= cnt_q + 1'b1;
  end

  assign log_count = cnt_q;
`else
  assign log_count = '0;
`endif

endmodule
